// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: computes the next PC and captures fetched instructions into the
// IF/ID pipeline register. It also handles stall, redirect and misaligned-target fault.
module fetch_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC,
  input  logic [31:0]      imem_instr,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      PC_Next,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc_plus4,
  output logic             ifid_valid,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StFault = 1'b1;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic [31:0]      fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        redir_misaligned;
  logic [31:0] pc_plus4;

  assign redir_misaligned = redirect_valid & (redirect_target[1:0] != 2'b00);
  assign pc_plus4         = PC + 32'd4;

  // The PC register has no enable, so holding means feeding PC back to itself.
  always_comb begin
    PC_Next = pc_plus4;
    if (state_q == StFault) begin
      PC_Next = PC;
    end else if (redir_misaligned) begin
      PC_Next = PC;
    end else if (redirect_valid) begin
      PC_Next = redirect_target;
    end else if (stall) begin
      PC_Next = PC;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;

    if (state_q == StRun) begin
      if (redir_misaligned) begin
        instr_d      = NOP_INSTR;
        valid_d      = 1'b0;
        fault_d      = 1'b1;
        fault_addr_d = redirect_target;
        state_d      = StFault;
      end else if (redirect_valid) begin
        // Flush: one bubble; ifid_pc keeps the last captured address.
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else if (!stall) begin
        instr_d = imem_instr;
        pc_d    = PC;
        valid_d = 1'b1;
        count_d = count_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StRun;
      instr_q      <= NOP_INSTR;
      pc_q         <= 32'd0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  assign ifid_instr    = instr_q;
  assign ifid_pc       = pc_q;
  assign ifid_pc_plus4 = pc_q + 32'd4;
  assign ifid_valid    = valid_q;
  assign fault         = fault_q;
  assign fault_addr    = fault_addr_q;
  assign fetch_count   = count_q;

endmodule
